cordic_iter_ctrl: RTL and testbench
===================================

// Module: cordic_iter_ctrl
// PURPOSE
//  Sequencer for the iterative CORDIC core: runs the x/y/z 32-bit registered adders one micro-rotation per
//  clock. Generates load select, adder clock enable, per-path add/subtract (Cin) controls, shift amount
//  and arctan ROM address, and exposes a START/BUSY/DONE handshake to the host. One adder pass per iteration.
// PARAMETERS
//  N_ITER   16  number of micro-rotations per operation (1..32)
//  SHW      5   width of SHIFT/ITER/ATAN_ADDR (must satisfy 2**SHW >= N_ITER)
// PORTS
//  C          in   1    clock, rising edge, shared with the datapath adders
//  CLR_N      in   1    asynchronous active-low reset
//  START      in   1    request new operation; sampled only in IDLE and DONE
//  MODE       in   1    0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); captured on accepted START
//  Z_SIGN     in   1    MSB of registered z adder output
//  Y_SIGN     in   1    MSB of registered y adder output
//  BUSY       out  1    high from LOAD through last ITER cycle
//  DONE       out  1    one-cycle pulse; x/y/z adder outputs hold the final result in that cycle
//  LOAD       out  1    selects initial operands into adder A inputs (x0,y0,z0)
//  CE         out  1    clock enable to all three adders
//  SUB_X      out  1    1 = x path subtracts (Cin=1, B inverted)
//  SUB_Y      out  1    1 = y path subtracts
//  SUB_Z      out  1    1 = z path subtracts
//  SHIFT      out  SHW  arithmetic right-shift for cross terms = current iteration index
//  ATAN_ADDR  out  SHW  arctan ROM address = current iteration index
// BEHAVIOUR
//  Reset (CLR_N=0, async): state IDLE; BUSY=DONE=LOAD=CE=0; SUB_X=SUB_Y=SUB_Z=0; SHIFT=ATAN_ADDR=0; mode reg=0.
//  All outputs registered/decoded from state + counter only, except SUB_* which also use Z_SIGN/Y_SIGN.
//  States: IDLE -> LOAD -> ITER -> DONE -> IDLE.
//   IDLE: START=1 -> LOAD (capture MODE). Otherwise stay.
//   LOAD (1 cycle): LOAD=1, CE=1, BUSY=1, SUB_*=0 (B inputs forced 0 by datapath); counter cleared to 0.
//   ITER (N_ITER cycles): CE=1, BUSY=1, SHIFT=ATAN_ADDR=counter; counter increments each cycle;
//     leave to DONE when counter==N_ITER-1 on that edge.
//   DONE (1 cycle): DONE=1, CE=0, BUSY=0; START=1 -> LOAD (back-to-back), else -> IDLE.
//  Direction (combinational in ITER, from registered previous-iteration result):
//   rotation : d=+1 iff Z_SIGN=0 -> SUB_X=~Z_SIGN, SUB_Y=Z_SIGN, SUB_Z=~Z_SIGN
//   vectoring: d=+1 iff Y_SIGN=1 -> SUB_X=Y_SIGN,  SUB_Y=~Y_SIGN, SUB_Z=Y_SIGN
//  Latency: START accepted at edge k -> LOAD in cycle k+1 -> DONE high in cycle k+N_ITER+2.
//  Throughput: one operation per N_ITER+2 cycles with START held high.
//  START while in LOAD/ITER ignored (no queuing); MODE change mid-operation ignored.
//  Counter wrap: counter never exceeds N_ITER-1; with N_ITER=2**SHW no overflow past terminal value.
//  CE=0 in IDLE/DONE: adder outputs frozen, result stable from DONE until next LOAD.
//  Reset mid-operation: immediate return to IDLE, no DONE issued; datapath contents undefined.
// STRUCTURE
//  Shared include cordic_defs.vh: state encodings (IDLE,LOAD,ITER,DONE, 2-bit), MODE_ROT=0/MODE_VEC=1,
//  default N_ITER, SHW.
//  One sub-module: cordic_iter_counter (SHW-bit counter, sync clear, enable, terminal-count flag at N_ITER-1).
//  FSM, mode register and direction decode stay in cordic_iter_ctrl.
// TESTING
//  1 Reset: CLR_N low mid-ITER (counter=7) -> all outputs 0 asynchronously, state IDLE, no DONE pulse.
//  2 Single rotation, N_ITER=16: START pulse at edge 0 -> LOAD cycle 1, ITER cycles 2..17 with
//    SHIFT 0..15, DONE only in cycle 18, BUSY high cycles 1..17.
//  3 Direction decode: MODE=0, Z_SIGN=0 -> SUB_X=1,SUB_Y=0,SUB_Z=1; Z_SIGN=1 -> 0,1,0; MODE=1, Y_SIGN=1 -> 1,0,1.
//  4 Back-to-back: START held high -> DONE every 18 cycles, LOAD in the cycle right after each DONE.
//  5 Ignored START: pulse START at ITER index 5 -> no restart, DONE still at cycle 18, MODE unchanged.
//  6 Closed loop with adders + atan ROM: rotate x0=0x4DBA76D4 (K*2^31), z0=pi/6 -> y~0.5, x~0.866 within 2^-14.

Source files
------------

// File: rtl/cordic_iter_ctrl_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer: state encoding,
// mode encoding, default sizing and the per-iteration direction decode.
package cordic_iter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam int N_ITER_DEF = 16;
  localparam int SHW_DEF    = 5;

  typedef struct packed {
    logic sub_x;
    logic sub_y;
    logic sub_z;
  } dir_t;

  // d=+1 means x and z subtract while y adds; d=-1 is the mirror image.
  function automatic dir_t decode_dir(input logic mode, input logic z_sign, input logic y_sign);
    logic d_pos;
    d_pos = (mode == MODE_ROT) ? ~z_sign : y_sign;
    return '{sub_x: d_pos, sub_y: ~d_pos, sub_z: d_pos};
  endfunction

endpackage

// File: rtl/cordic_iter_ctrl_counter.sv
// Iteration index counter: synchronous clear, count enable, terminal-count flag
// at N_ITER-1. Wraps to zero after the terminal value so it never exceeds it.
module cordic_iter_counter
  import cordic_iter_ctrl_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int SHW    = SHW_DEF
) (
  input  logic           c,
  input  logic           clr_n,
  input  logic           clear,
  input  logic           en,
  output logic [SHW-1:0] count,
  output logic           tc
);

  localparam logic [SHW-1:0] LAST = SHW'(N_ITER - 1);

  assign tc = (count == LAST);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for the iterative CORDIC core: one micro-rotation per clock on the
// x/y/z registered adders, with a START/BUSY/DONE handshake to the host.
module cordic_iter_ctrl
  import cordic_iter_ctrl_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int SHW    = SHW_DEF
) (
  input  logic           c,
  input  logic           clr_n,
  input  logic           start,
  input  logic           mode,
  input  logic           z_sign,
  input  logic           y_sign,
  output logic           busy,
  output logic           done,
  output logic           load,
  output logic           ce,
  output logic           sub_x,
  output logic           sub_y,
  output logic           sub_z,
  output logic [SHW-1:0] shift,
  output logic [SHW-1:0] atan_addr
);

  if (N_ITER < 1 || N_ITER > 32 || (1 << SHW) < N_ITER) begin : g_bad_param
    $error("cordic_iter_ctrl: N_ITER must be 1..32 and fit in SHW bits");
  end

  state_t         state, state_nxt;
  logic           mode_q;
  logic [SHW-1:0] count;
  logic           tc;
  logic           accept;
  dir_t           dir;

  // START is only honoured between operations; anything during LOAD/ITER is dropped.
  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  cordic_iter_counter #(
    .N_ITER (N_ITER),
    .SHW    (SHW)
  ) u_counter (
    .c     (c),
    .clr_n (clr_n),
    .clear (state == ST_LOAD),
    .en    (state == ST_ITER),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_ROT;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q <= mode;
      end
    end
  end

  // Signs come from the adder registers, i.e. the previous iteration's result.
  assign dir = decode_dir(mode_q, z_sign, y_sign);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    ce        = 1'b0;
    sub_x     = 1'b0;
    sub_y     = 1'b0;
    sub_z     = 1'b0;
    shift     = '0;
    atan_addr = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load      = 1'b1;
        ce        = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_ITER;
      end
      ST_ITER: begin
        ce        = 1'b1;
        busy      = 1'b1;
        shift     = count;
        atan_addr = count;
        sub_x     = dir.sub_x;
        sub_y     = dir.sub_y;
        sub_z     = dir.sub_z;
        if (tc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = accept ? ST_LOAD : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: phase-count reference model, direction
// table, timing/handshake sequences, random traffic and a closed CORDIC loop.
module tb_cordic_iter_ctrl;

  localparam int N   = 16;
  localparam int SHW = 5;

  logic           c = 1'b0;
  logic           clr_n;
  logic           start, mode;
  logic           z_drv, y_drv, loop_en;
  logic           z_sign, y_sign;
  logic           busy, done, load, ce, sub_x, sub_y, sub_z;
  logic [SHW-1:0] shift, atan_addr;

  int checks = 0;
  int errors = 0;

  always #5 c = ~c;

  cordic_iter_ctrl #(.N_ITER(N), .SHW(SHW)) dut (
    .c         (c),
    .clr_n     (clr_n),
    .start     (start),
    .mode      (mode),
    .z_sign    (z_sign),
    .y_sign    (y_sign),
    .busy      (busy),
    .done      (done),
    .load      (load),
    .ce        (ce),
    .sub_x     (sub_x),
    .sub_y     (sub_y),
    .sub_z     (sub_z),
    .shift     (shift),
    .atan_addr (atan_addr)
  );

  // Closed-loop datapath: three registered adders and an arctan table (Q2.30 angles).
  logic signed [31:0] xr = '0, yr = '0, zr = '0;
  logic signed [31:0] x0 = '0, y0 = '0, z0 = '0;
  logic signed [31:0] bx, by, bz, ax, ay, az;
  logic signed [31:0] atan_rom [0:31];

  assign ax = load ? x0 : xr;
  assign ay = load ? y0 : yr;
  assign az = load ? z0 : zr;
  assign bx = load ? 32'sd0 : (yr >>> shift);
  assign by = load ? 32'sd0 : (xr >>> shift);
  assign bz = load ? 32'sd0 : atan_rom[atan_addr];

  always @(posedge c) begin
    if (ce) begin
      xr <= sub_x ? ax - bx : ax + bx;
      yr <= sub_y ? ay - by : ay + by;
      zr <= sub_z ? az - bz : az + bz;
    end
  end

  assign z_sign = loop_en ? zr[31] : z_drv;
  assign y_sign = loop_en ? yr[31] : y_drv;

  // Reference model: t counts cycles since an accepted START (-1 = idle).
  // t=0 is the load cycle, 1..N the micro-rotations, N+1 the done cycle.
  int   t = -1;
  logic m_mode = 1'b0;

  function automatic logic [16:0] model_exp();
    logic           l, it, d;
    logic [SHW-1:0] s;
    int             dir;
    l   = (t == 0);
    it  = (t >= 1 && t <= N);
    d   = (t == N + 1);
    s   = it ? SHW'(t - 1) : '0;
    dir = 0;
    if (it) begin
      if (m_mode == 1'b0) dir = z_sign ? -1 : 1;   // rotation: drive z toward 0
      else                dir = y_sign ? 1 : -1;   // vectoring: drive y toward 0
    end
    return {l | it, d, l, l | it, dir > 0, dir < 0, dir > 0, s, s};
  endfunction

  function automatic logic [16:0] pack_dut();
    return {busy, done, load, ce, sub_x, sub_y, sub_z, shift, atan_addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    int diff;
    checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge c);
    if (!clr_n) begin
      t = -1;
      m_mode = 1'b0;
    end else if (t < 0 || t == N + 1) begin
      if (start) begin
        t = 0;
        m_mode = mode;
      end else begin
        t = -1;
      end
    end else begin
      t++;
    end
    @(negedge c);
    check("model", 32'(pack_dut()), 32'(model_exp()));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic       mode;
    logic       zs;
    logic       ys;
    logic [2:0] exp_sub;
  } vec_t;

  vec_t vecs [8];
  int   last_done;
  logic exp_load_next;
  int   done_seen;

  initial begin
    real r;
    r = 1.0;
    for (int i = 0; i < 32; i++) begin
      atan_rom[i] = 32'($rtoi($atan(r) * 1073741824.0));
      r = r / 2.0;
    end

    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'b101};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'b101};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b010};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b010};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b010};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 3'b010};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 3'b101};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 3'b101};

    clr_n = 1'b0; start = 1'b0; mode = 1'b0;
    z_drv = 1'b0; y_drv = 1'b0; loop_en = 1'b0;
    #1;
    check("reset outputs", 32'(pack_dut()), 32'd0);
    tick(); tick();
    clr_n = 1'b1;
    tick();

    // Single rotation timeline, cycle numbers relative to the accepting edge.
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int idx = 1; idx <= 20; idx++) begin
      check("t2 load", 32'(load), 32'(idx == 1));
      check("t2 busy", 32'(busy), 32'(idx >= 1 && idx <= 17));
      check("t2 done", 32'(done), 32'(idx == 18));
      if (idx >= 2 && idx <= 17) check("t2 shift", 32'(shift), 32'(idx - 2));
      tick();
    end

    // Direction decode table, one operation per entry.
    foreach (vecs[i]) begin
      mode = vecs[i].mode; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      z_drv = vecs[i].zs; y_drv = vecs[i].ys;
      #1;
      check("dir table", 32'({sub_x, sub_y, sub_z}), 32'(vecs[i].exp_sub));
      wait_done("dir done");
      tick();
    end
    z_drv = 1'b0; y_drv = 1'b0;

    // START / MODE changes mid-operation are ignored.
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int idx = 1; idx <= 20; idx++) begin
      if (idx == 7) begin
        check("t5 at iter 5", 32'(shift), 32'd5);
        start = 1'b1; mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (idx >= 8 && idx <= 17) check("t5 mode kept", 32'({sub_x, sub_y, sub_z}), 32'b101);
      check("t5 done", 32'(done), 32'(idx == 18));
      check("t5 no reload", 32'(load), 32'(idx == 1));
      tick();
    end
    mode = 1'b0;

    // Back-to-back with START held high.
    start = 1'b1;
    last_done = -1;
    exp_load_next = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (exp_load_next) check("b2b load after done", 32'(load), 32'd1);
      exp_load_next = done;
      if (done) begin
        if (last_done >= 0) check("b2b period", 32'(i - last_done), 32'(N + 2));
        last_done = i;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    check("b2b drained", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an operation (counter at 7).
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int n = 0;
      while (shift != SHW'(7) && n < 30) begin
        tick();
        n++;
      end
    end
    check("t1 reached iter 7", 32'(shift), 32'd7);
    #2 clr_n = 1'b0;
    #1;
    check("t1 async clear", 32'(pack_dut()), 32'd0);
    t = -1; m_mode = 1'b0;
    tick(); tick();
    clr_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("t1 no done after reset", 32'(done_seen), 32'd0);

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom);
      z_drv = 1'($urandom);
      y_drv = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 clr_n = 1'b0;
        #1;
        check("rand async reset", 32'(pack_dut()), 32'd0);
        t = -1; m_mode = 1'b0;
        #1 clr_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 25; i++) tick();

    // Closed loop: rotate (K, 0) by pi/6 -> (cos, sin) in Q1.31.
    x0 = 32'sh4DBA76D4;
    y0 = 32'sd0;
    z0 = 32'($rtoi(3.14159265358979 / 6.0 * 1073741824.0));
    loop_en = 1'b1;
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("loop done");
    check_tol("loop y", int'(yr), $rtoi(0.5 * 2147483648.0), 1 << 17);
    check_tol("loop x", int'(xr), $rtoi($cos(3.14159265358979 / 6.0) * 2147483648.0), 1 << 17);
    tick();
    loop_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
